// File: rtl/ddr4_axi_arb_pkg.sv
// rtl/ddr4_axi_arb_pkg.sv - shared command encodings and types for the DDR4 AXI read/write command arbiter
package ddr4_axi_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Default address width of a command word; the top re-parameterises its own datapath.
  localparam int ARB_AW = 32;

  // Phase is the direction of the most recent grant.
  typedef enum logic {PH_RD = 1'b0, PH_WR = 1'b1} phase_t;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ARB_AW-1:0] addr;
  } arb_cmd_t;

endpackage

// File: rtl/ddr4_axi_arb_if.sv
// rtl/ddr4_axi_arb_if.sv - requester, read-buffer and MC app command handshake bundle
interface ddr4_axi_arb_if #(
  parameter int AW = 32
);

  logic          wr_cmd_en;
  logic [AW-1:0] wr_cmd_addr;
  logic          wr_cmd_rdy;
  logic          rd_cmd_en;
  logic [AW-1:0] rd_cmd_addr;
  logic          rd_cmd_rdy;
  logic          r_data_rdy;
  logic          mc_app_en;
  logic [2:0]    mc_app_cmd;
  logic [AW-1:0] mc_app_addr;
  logic          mc_app_rdy;

  // Arbiter side.
  modport slave (
    input  wr_cmd_en, wr_cmd_addr, rd_cmd_en, rd_cmd_addr, r_data_rdy, mc_app_rdy,
    output wr_cmd_rdy, rd_cmd_rdy, mc_app_en, mc_app_cmd, mc_app_addr
  );

  // Environment side: both sequencers, the read buffers and the memory controller.
  modport master (
    output wr_cmd_en, wr_cmd_addr, rd_cmd_en, rd_cmd_addr, r_data_rdy, mc_app_rdy,
    input  wr_cmd_rdy, rd_cmd_rdy, mc_app_en, mc_app_cmd, mc_app_addr
  );

endinterface

// File: rtl/ddr4_axi_arb_out_stage.sv
// rtl/ddr4_axi_arb_out_stage.sv - one-entry registered valid/ready stage driving the MC app command
module ddr4_axi_arb_out_stage
  import ddr4_axi_arb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [2:0]    load_cmd,
  input  logic [AW-1:0] load_addr,
  input  logic          out_rdy,
  output logic          out_en,
  output logic [2:0]    out_cmd,
  output logic [AW-1:0] out_addr
);

  // Load on grant (only offered when the slot is free), hold while stalled, drop valid on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_en   <= 1'b0;
      out_cmd  <= CMD_WRITE;
      out_addr <= '0;
    end else if (load) begin
      out_en   <= 1'b1;
      out_cmd  <= load_cmd;
      out_addr <= load_addr;
    end else if (out_rdy) begin
      out_en   <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr4_axi_rw_cmd_arbiter.sv
// rtl/ddr4_axi_rw_cmd_arbiter.sv - run-grouping read/write command arbiter for the MC app port (stats: DDR4_AXI_ARB_STATS_EN)
module ddr4_axi_rw_cmd_arbiter
  import ddr4_axi_arb_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_MAX_RUN        = 16,
  parameter int C_STARVE_LIMIT   = 8,
  parameter int C_CNT_WIDTH      = 5
) (
  input  logic          clk,
  input  logic          reset,
  ddr4_axi_arb_if.slave bus,
  output logic [31:0]   stat_rd_grants,
  output logic [31:0]   stat_wr_grants,
  output logic [31:0]   stat_switches
);

  localparam logic [C_CNT_WIDTH-1:0] MAX_RUN    = C_CNT_WIDTH'(C_MAX_RUN);
  localparam logic [C_CNT_WIDTH-1:0] STARVE_LIM = C_CNT_WIDTH'(C_STARVE_LIMIT);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE    = C_CNT_WIDTH'(1);

  phase_t                 phase_q, phase_d;
  logic [C_CNT_WIDTH-1:0] run_q, run_d;
  logic [C_CNT_WIDTH-1:0] starve_rd_q, starve_rd_d;
  logic [C_CNT_WIDTH-1:0] starve_wr_q, starve_wr_d;
  logic                   rd_elig, wr_elig, slot_free, keep;
  logic                   rd_rdy, wr_rdy, rd_gnt, wr_gnt, switch_phase;
  logic                   stage_en;

  // Phase, run length and per-direction starvation counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_RD;
      run_q       <= '0;
      starve_rd_q <= '0;
      starve_wr_q <= '0;
    end else begin
      phase_q     <= phase_d;
      run_q       <= run_d;
      starve_rd_q <= starve_rd_d;
      starve_wr_q <= starve_wr_d;
    end
  end

  // Grant decision and next state. Each ready is built from the other side's eligibility only,
  // so a requester never sees its own enable looped back into its ready.
  always_comb begin
    rd_elig   = bus.rd_cmd_en & bus.r_data_rdy;
    wr_elig   = bus.wr_cmd_en;
    slot_free = ~stage_en | bus.mc_app_rdy;
    keep      = (run_q < MAX_RUN) &&
                (((phase_q == PH_RD) ? starve_wr_q : starve_rd_q) < STARVE_LIM);
    if (phase_q == PH_RD) begin
      rd_rdy = slot_free & bus.r_data_rdy & (~wr_elig | keep);
      wr_rdy = slot_free & (~rd_elig | ~keep);
    end else begin
      rd_rdy = slot_free & bus.r_data_rdy & (~wr_elig | ~keep);
      wr_rdy = slot_free & (~rd_elig | keep);
    end
    rd_gnt       = rd_rdy & bus.rd_cmd_en;
    wr_gnt       = wr_rdy & bus.wr_cmd_en;
    switch_phase = (phase_q == PH_RD) ? wr_gnt : rd_gnt;

    phase_d = phase_q;
    run_d   = run_q;
    if (switch_phase) begin
      phase_d = rd_gnt ? PH_RD : PH_WR;
      run_d   = CNT_ONE;
    end else if ((rd_gnt || wr_gnt) && (run_q < MAX_RUN)) begin
      run_d   = run_q + CNT_ONE;
    end

    starve_rd_d = starve_rd_q;
    if (rd_gnt || !rd_elig)          starve_rd_d = '0;
    else if (starve_rd_q < STARVE_LIM) starve_rd_d = starve_rd_q + CNT_ONE;

    starve_wr_d = starve_wr_q;
    if (wr_gnt || !wr_elig)          starve_wr_d = '0;
    else if (starve_wr_q < STARVE_LIM) starve_wr_d = starve_wr_q + CNT_ONE;
  end

  assign bus.rd_cmd_rdy = rd_rdy;
  assign bus.wr_cmd_rdy = wr_rdy;
  assign bus.mc_app_en  = stage_en;

  ddr4_axi_arb_out_stage #(
    .AW (C_AXI_ADDR_WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (rd_gnt | wr_gnt),
    .load_cmd  (rd_gnt ? CMD_READ : CMD_WRITE),
    .load_addr (rd_gnt ? bus.rd_cmd_addr : bus.wr_cmd_addr),
    .out_rdy   (bus.mc_app_rdy),
    .out_en    (stage_en),
    .out_cmd   (bus.mc_app_cmd),
    .out_addr  (bus.mc_app_addr)
  );

`ifdef DDR4_AXI_ARB_STATS_EN
  logic [31:0] st_rd_q, st_wr_q, st_sw_q;

  // Saturating grant and phase-flip counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_rd_q <= '0;
      st_wr_q <= '0;
      st_sw_q <= '0;
    end else begin
      if (rd_gnt && (st_rd_q != '1))       st_rd_q <= st_rd_q + 32'd1;
      if (wr_gnt && (st_wr_q != '1))       st_wr_q <= st_wr_q + 32'd1;
      if (switch_phase && (st_sw_q != '1)) st_sw_q <= st_sw_q + 32'd1;
    end
  end

  assign stat_rd_grants = st_rd_q;
  assign stat_wr_grants = st_wr_q;
  assign stat_switches  = st_sw_q;
`else
  assign stat_rd_grants = '0;
  assign stat_wr_grants = '0;
  assign stat_switches  = '0;
`endif

endmodule

// File: tb/tb_ddr4_axi_rw_cmd_arbiter.sv
// tb/tb_ddr4_axi_rw_cmd_arbiter.sv - directed self-checking bench for ddr4_axi_rw_cmd_arbiter
module tb_ddr4_axi_rw_cmd_arbiter;
  import ddr4_axi_arb_pkg::*;

`ifdef DDR4_AXI_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [31:0] RA = 32'h1000_0000;
  localparam logic [31:0] WA = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en, rdata_rdy, mc_rdy;
  logic [31:0] rd_addr, wr_addr;
  logic [31:0] st_rd_a, st_wr_a, st_sw_a, st_rd_b, st_wr_b, st_sw_b;
  logic [15:0] pat_a, pat_b;
  int          n_cmp, n_err;

  always #5 clk = ~clk;

  ddr4_axi_arb_if #(.AW(32)) bus_a ();
  ddr4_axi_arb_if #(.AW(32)) bus_b ();

  assign bus_a.rd_cmd_en   = rd_en;
  assign bus_a.wr_cmd_en   = wr_en;
  assign bus_a.rd_cmd_addr = rd_addr;
  assign bus_a.wr_cmd_addr = wr_addr;
  assign bus_a.r_data_rdy  = rdata_rdy;
  assign bus_a.mc_app_rdy  = mc_rdy;
  assign bus_b.rd_cmd_en   = rd_en;
  assign bus_b.wr_cmd_en   = wr_en;
  assign bus_b.rd_cmd_addr = rd_addr;
  assign bus_b.wr_cmd_addr = wr_addr;
  assign bus_b.r_data_rdy  = rdata_rdy;
  assign bus_b.mc_app_rdy  = mc_rdy;

  ddr4_axi_rw_cmd_arbiter #(
    .C_AXI_ADDR_WIDTH (32), .C_MAX_RUN (4), .C_STARVE_LIMIT (8), .C_CNT_WIDTH (5)
  ) u_dut_a (
    .clk (clk), .reset (reset), .bus (bus_a),
    .stat_rd_grants (st_rd_a), .stat_wr_grants (st_wr_a), .stat_switches (st_sw_a)
  );

  ddr4_axi_rw_cmd_arbiter #(
    .C_AXI_ADDR_WIDTH (32), .C_MAX_RUN (16), .C_STARVE_LIMIT (3), .C_CNT_WIDTH (5)
  ) u_dut_b (
    .clk (clk), .reset (reset), .bus (bus_b),
    .stat_rd_grants (st_rd_b), .stat_wr_grants (st_wr_b), .stat_switches (st_sw_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] st(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; rdata_rdy = 1'b0; mc_rdy = 1'b0;
    rd_addr = '0; wr_addr = '0;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0;
    pat_a = 16'hF0F0;  // 1 = write grant, bit k = cycle k
    pat_b = 16'h8E38;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_en",     64'(bus_a.mc_app_en),   64'd0);
    check_eq("rst_cmd",    64'(bus_a.mc_app_cmd),  64'd0);
    check_eq("rst_addr",   64'(bus_a.mc_app_addr), 64'd0);
    check_eq("rst_rd_rdy", 64'(bus_a.rd_cmd_rdy),  64'd0);
    check_eq("rst_wr_rdy", 64'(bus_a.wr_cmd_rdy),  64'd1);
    check_eq("rst_st_rd",  64'(st_rd_a), 64'd0);
    check_eq("rst_st_sw",  64'(st_sw_a), 64'd0);
    next_cycle();

    // Reads only, full throughput, one-cycle latency
    do_reset();
    rd_en = 1'b1; rdata_rdy = 1'b1; mc_rdy = 1'b1;
    for (int k = 0; k < 21; k++) begin
      rd_addr = RA + 32'(k);
      if (k == 20) rd_en = 1'b0;
      @(negedge clk);
      if (k < 20) check_eq("t1_rd_rdy", 64'(bus_a.rd_cmd_rdy), 64'd1);
      check_eq("t1_en", 64'(bus_a.mc_app_en), 64'(k > 0));
      if (k > 0) begin
        check_eq("t1_cmd",  64'(bus_a.mc_app_cmd),  64'(CMD_READ));
        check_eq("t1_addr", 64'(bus_a.mc_app_addr), 64'(RA + 32'(k - 1)));
      end
      next_cycle();
    end
    @(negedge clk);
    check_eq("t1_drain_en", 64'(bus_a.mc_app_en), 64'd0);
    check_eq("t1_st_rd", 64'(st_rd_a), st(20));
    check_eq("t1_st_wr", 64'(st_wr_a), st(0));
    check_eq("t1_st_sw", 64'(st_sw_a), st(0));
    next_cycle();

    // Both requesting: run limit on A, starvation limit on B
    do_reset();
    rd_en = 1'b1; wr_en = 1'b1; rdata_rdy = 1'b1; mc_rdy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      rd_addr = RA + 32'(k);
      wr_addr = WA + 32'(k);
      if (k == 16) begin rd_en = 1'b0; wr_en = 1'b0; end
      @(negedge clk);
      if (k < 16) begin
        check_eq("t2_a_wr_rdy", 64'(bus_a.wr_cmd_rdy), 64'(pat_a[4'(k)]));
        check_eq("t2_a_rd_rdy", 64'(bus_a.rd_cmd_rdy), 64'(!pat_a[4'(k)]));
        check_eq("t3_b_wr_rdy", 64'(bus_b.wr_cmd_rdy), 64'(pat_b[4'(k)]));
        check_eq("t3_b_rd_rdy", 64'(bus_b.rd_cmd_rdy), 64'(!pat_b[4'(k)]));
      end
      if (k > 0) begin
        check_eq("t2_a_cmd",  64'(bus_a.mc_app_cmd),  64'(pat_a[4'(k - 1)] ? CMD_WRITE : CMD_READ));
        check_eq("t2_a_addr", 64'(bus_a.mc_app_addr), 64'((pat_a[4'(k - 1)] ? WA : RA) + 32'(k - 1)));
        check_eq("t3_b_cmd",  64'(bus_b.mc_app_cmd),  64'(pat_b[4'(k - 1)] ? CMD_WRITE : CMD_READ));
        check_eq("t3_b_addr", 64'(bus_b.mc_app_addr), 64'((pat_b[4'(k - 1)] ? WA : RA) + 32'(k - 1)));
      end
      next_cycle();
    end
    check_eq("t2_a_st_rd", 64'(st_rd_a), st(8));
    check_eq("t2_a_st_wr", 64'(st_wr_a), st(8));
    check_eq("t2_a_st_sw", 64'(st_sw_a), st(3));
    check_eq("t3_b_st_rd", 64'(st_rd_b), st(9));
    check_eq("t3_b_st_wr", 64'(st_wr_b), st(7));
    check_eq("t3_b_st_sw", 64'(st_sw_b), st(5));

    // Read blocked by full read buffers, then released
    do_reset();
    rd_en = 1'b1; rdata_rdy = 1'b0; mc_rdy = 1'b1; rd_addr = RA + 32'h40;
    repeat (3) begin
      @(negedge clk);
      check_eq("t4_rd_rdy_blk", 64'(bus_a.rd_cmd_rdy), 64'd0);
      check_eq("t4_en_blk",     64'(bus_a.mc_app_en),  64'd0);
      next_cycle();
    end
    rdata_rdy = 1'b1;
    @(negedge clk);
    check_eq("t4_rd_rdy_rel", 64'(bus_a.rd_cmd_rdy), 64'd1);
    next_cycle();
    rd_en = 1'b0;
    @(negedge clk);
    check_eq("t4_en",   64'(bus_a.mc_app_en),   64'd1);
    check_eq("t4_cmd",  64'(bus_a.mc_app_cmd),  64'(CMD_READ));
    check_eq("t4_addr", 64'(bus_a.mc_app_addr), 64'(RA + 32'h40));
    next_cycle();

    // MC back-pressure holds the stage and blocks both requesters
    do_reset();
    rd_en = 1'b1; rdata_rdy = 1'b1; mc_rdy = 1'b0; rd_addr = RA + 32'h50; wr_addr = WA + 32'h50;
    @(negedge clk);
    check_eq("t5_first_rd_rdy", 64'(bus_a.rd_cmd_rdy), 64'd1);
    next_cycle();
    rd_addr = RA + 32'h51; wr_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("t5_hold_en",   64'(bus_a.mc_app_en),   64'd1);
      check_eq("t5_hold_cmd",  64'(bus_a.mc_app_cmd),  64'(CMD_READ));
      check_eq("t5_hold_addr", 64'(bus_a.mc_app_addr), 64'(RA + 32'h50));
      check_eq("t5_hold_rd",   64'(bus_a.rd_cmd_rdy),  64'd0);
      check_eq("t5_hold_wr",   64'(bus_a.wr_cmd_rdy),  64'd0);
      next_cycle();
    end
    mc_rdy = 1'b1;
    @(negedge clk);
    check_eq("t5_rel_addr", 64'(bus_a.mc_app_addr), 64'(RA + 32'h50));
    check_eq("t5_rel_rd",   64'(bus_a.rd_cmd_rdy),  64'd1);
    check_eq("t5_rel_wr",   64'(bus_a.wr_cmd_rdy),  64'd0);
    next_cycle();
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check_eq("t5_next_en",   64'(bus_a.mc_app_en),   64'd1);
    check_eq("t5_next_addr", 64'(bus_a.mc_app_addr), 64'(RA + 32'h51));
    next_cycle();

    // Reset with the stage full in write phase
    do_reset();
    wr_en = 1'b1; rdata_rdy = 1'b1; mc_rdy = 1'b0; wr_addr = WA + 32'h60;
    @(negedge clk);
    check_eq("t6_wr_rdy", 64'(bus_a.wr_cmd_rdy), 64'd1);
    next_cycle();
    wr_en = 1'b0;
    @(negedge clk);
    check_eq("t6_full_en",  64'(bus_a.mc_app_en),  64'd1);
    check_eq("t6_full_cmd", 64'(bus_a.mc_app_cmd), 64'(CMD_WRITE));
    check_eq("t6_st_wr",    64'(st_wr_a), st(1));
    check_eq("t6_st_sw",    64'(st_sw_a), st(1));
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    rd_en = 1'b1; wr_en = 1'b1; mc_rdy = 1'b1; rd_addr = RA + 32'h70; wr_addr = WA + 32'h70;
    @(negedge clk);
    check_eq("t6_rst_en",    64'(bus_a.mc_app_en),   64'd0);
    check_eq("t6_rst_cmd",   64'(bus_a.mc_app_cmd),  64'd0);
    check_eq("t6_rst_addr",  64'(bus_a.mc_app_addr), 64'd0);
    check_eq("t6_rst_st_wr", 64'(st_wr_a), 64'd0);
    check_eq("t6_rst_st_sw", 64'(st_sw_a), 64'd0);
    check_eq("t6_phase_rd",  64'(bus_a.rd_cmd_rdy),  64'd1);
    check_eq("t6_phase_wr",  64'(bus_a.wr_cmd_rdy),  64'd0);
    next_cycle();
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check_eq("t6_after_cmd",  64'(bus_a.mc_app_cmd),  64'(CMD_READ));
    check_eq("t6_after_addr", 64'(bus_a.mc_app_addr), 64'(RA + 32'h70));
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
